// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII codes, string geometry,
// and the ans_to_ascii state encoding.
package calc_pkg;

  localparam logic [7:0] CHAR_NL       = 8'h0A;
  localparam logic [7:0] CHAR_MINUS    = 8'h2D;
  localparam logic [7:0] CHAR_ZERO     = 8'h30;
  localparam logic [7:0] CHAR_LBRACKET = 8'h5B;
  localparam logic [7:0] CHAR_RBRACKET = 8'h5D;

  localparam int STR_CHARS  = 32;
  localparam int STR_W      = STR_CHARS * 8;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = BCD_DIGITS * 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_SCAN,
    S_EMIT,
    S_DONE
  } a2a_state_t;

endpackage

// File: rtl/ans_to_ascii_if.sv
// Request/result bundle between a result producer and ans_to_ascii.
// The master issues start/value; the slave returns the string.
interface ans_to_ascii_if;
  import calc_pkg::*;

  logic             start;
  logic [31:0]      value;
  logic [STR_W-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, value,
    input  out, busy, done
  );

  modport slave (
    input  start, value,
    output out, busy, done
  );

endinterface

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to BCD digits >= 5,
// then shift {bcd, mag} left by one bit.
module dabble_step (
  input  logic [39:0] bcd,
  input  logic [31:0] mag,
  output logic [39:0] bcd_next,
  output logic [31:0] mag_next
);

  logic [39:0] adj;

  always_comb begin
    adj = bcd;
    for (int j = 0; j < 10; j++) begin
      if (bcd[4*j +: 4] >= 4'd5)
        adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
    end
    {bcd_next, mag_next} = {adj[38:0], mag, 1'b0};
  end

endmodule

// File: rtl/ans_to_ascii.sv
// Converts a 32-bit result into a newline-terminated decimal string,
// double-dabble over 32 cycles then one output byte per cycle.
module ans_to_ascii
  import calc_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  ans_to_ascii_if.slave      bus
);

  a2a_state_t state, state_nx;

  logic [31:0]      val_q;
  logic [31:0]      mag;
  logic [39:0]      bcd;
  logic [5:0]       iter;
  logic             sign;
  logic [3:0]       ndig;
  logic [3:0]       ptr;
  logic [STR_W-1:0] out_q;
  logic             busy_q;
  logic             done_q;

  logic [39:0] bcd_step;
  logic [31:0] mag_step;
  logic        ld_sign;
  logic [3:0]  scan_d;
  logic [3:0]  k;
  logic [3:0]  dig;
  logic [7:0]  emit_byte;
  logic        emit_last;
  logic        accept;

  dabble_step u_step (
    .bcd      (bcd),
    .mag      (mag),
    .bcd_next (bcd_step),
    .mag_next (mag_step)
  );

  assign accept  = bus.start &&
                   (state == S_IDLE || state == S_DONE);
  assign ld_sign = SIGNED & val_q[31];

  always_comb begin
    scan_d = 4'd1;
    for (int j = 0; j < 10; j++) begin
      if (bcd[4*j +: 4] != 4'd0)
        scan_d = 4'(j + 1);
    end
  end

  // k is the position within the digit run, past any sign byte
  always_comb begin
    k   = ptr - {3'b000, sign};
    dig = 4'd0;
    for (int j = 0; j < 10; j++) begin
      if (4'(j) == ndig - 4'd1 - k)
        dig = bcd[4*j +: 4];
    end
    emit_last = 1'b0;
    if (sign && ptr == 4'd0) begin
      emit_byte = CHAR_MINUS;
    end else if (k == ndig) begin
      emit_byte = CHAR_NL;
      emit_last = 1'b1;
    end else begin
      emit_byte = CHAR_ZERO + {4'd0, dig};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (accept) state_nx = S_LOAD;
      S_LOAD: state_nx = S_CONV;
      S_CONV: if (iter == 6'd31) state_nx = S_SCAN;
      S_SCAN: state_nx = S_EMIT;
      S_EMIT: if (emit_last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '0;
      mag    <= '0;
      bcd    <= '0;
      iter   <= '0;
      sign   <= 1'b0;
      ndig   <= '0;
      ptr    <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            val_q  <= bus.value;
            out_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          sign <= ld_sign;
          mag  <= ld_sign ? (~val_q + 32'd1) : val_q;
          bcd  <= '0;
          iter <= '0;
        end
        S_CONV: begin
          bcd  <= bcd_step;
          mag  <= mag_step;
          iter <= iter + 6'd1;
        end
        S_SCAN: begin
          ndig <= scan_d;
          ptr  <= '0;
        end
        S_EMIT: begin
          for (int i = 0; i < 12; i++) begin
            if (ptr == 4'(i))
              out_q[STR_W-1-8*i -: 8] <= emit_byte;
          end
          ptr <= ptr + 4'd1;
          if (emit_last) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/ans_to_ascii.md
# ans_to_ascii

Converts a 32-bit calculator result into a newline-terminated ASCII decimal string in the same 256-bit packed-character format the calculator accepts on its input. It sits downstream of the expression evaluator and feeds the display/UART path. Its output can also be looped back into the evaluator for round-trip testing. It uses a multi-cycle double-dabble conversion followed by a byte-serial emit phase.

## Interface
- SIGNED, 1, 1: `value` is two's complement and negative results get a leading "-"; 0: `value` is unsigned.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE or DONE.
- value  input  32  result to convert; latched on the accepted `start`.
- out  output  256  packed string. Char 0 is out[255:248], char i is out[255-8i -: 8]. Unused bytes are 8'h00.
- busy  output  1  high from the accepted `start` until `done`.
- done  output  1  level; held high until the next accepted `start`.

## Operation
- States: IDLE, LOAD, CONV, SCAN, EMIT, DONE.
- IDLE/DONE with start=1: latch `value`, clear `out`, done<=0, busy<=1, go to LOAD.
- LOAD:
  - sign = SIGNED & value[31].
  - mag = sign ? -value : value, taken as a 32-bit unsigned magnitude. 0x80000000 yields 2147483648.
  - BCD register (40 bits, 10 digits) <= 0; iteration counter <= 0.
  - Go to CONV.
- CONV: one double-dabble iteration per cycle.
  - Add 3 to every BCD digit >= 5.
  - Shift {bcd, mag} left by 1.
  - Leave after 32 iterations.
- SCAN, single cycle:
  - Priority-encode the first nonzero BCD digit to get the digit count D (1..10). Value 0 gives D=1.
  - Byte pointer <= 0.
- EMIT: writes exactly one byte per cycle at the pointer, then increments the pointer.
  - Byte order: "-" if sign, then D digits most significant first (8'h30 + digit), then 8'h0A.
  - N = sign + D + 1 bytes total; N is at most 12.
  - After the newline: done<=1, busy<=0, go to DONE.
- DONE behaves like IDLE but keeps `out` and done=1.
- `start` while busy is ignored. Changes to `value` after latching are ignored.
- Reset (asynchronous, any state, including mid-CONV/EMIT):
  - state=IDLE, out=0, busy=0, done=0, all internal registers 0.

## Timing
- The accepting edge is E0.
- Edge E0+1: LOAD.
- Edges E0+2 .. E0+33: the 32 CONV iterations.
- Edge E0+34: SCAN.
- Edges E0+35 .. E0+34+N: EMIT.
- `done` is visible after edge E0+34+N. Latency is 34+N cycles, ranging from 36 (value 0) to 46 (12-byte result).
- `out` is only guaranteed final while done=1. During EMIT it grows one byte per cycle and the bytes beyond the pointer stay 0.
- A new `start` in DONE is accepted on the same edge that clears done. Back-to-back throughput is 35+N cycles.

## Structure
- Shared package `calc_pkg` holds:
  - ASCII constants CHAR_NL=8'h0A, CHAR_MINUS=8'h2D, CHAR_ZERO=8'h30, CHAR_RBRACKET, CHAR_LBRACKET.
  - The string width (32 chars × 8 bits).
  - This block's state encoding.
- Sub-module `dabble_step`: combinational add-3-and-shift over {40-bit BCD, 32-bit mag}. It is instantiated once and its result is registered in CONV.

## Test plan
- value=0, SIGNED=1 -> out[255:240]="0\n", rest 0; done exactly 36 cycles after the start edge.
- value=12345 -> out[255:208]="12345\n", out[207:0]=0; latency 40; busy high throughout, low with done.
- value=32'hFFFFFFF9:
  - SIGNED=1 -> "-7\n" (latency 37).
  - SIGNED=0 -> "4294967289\n" (latency 45).
- value=32'h80000000, SIGNED=1 -> "-2147483648\n", 12 bytes, latency 46.
- Pulse start with value=99, then pulse start with value=5 during CONV -> second start ignored; result "99\n".
- Assert rst mid-CONV:
  - out=0, busy=0, done=0 immediately, without waiting for a clock edge.
  - After release, start with value=7 -> "7\n".
  - Loop `out` back into the evaluator and check its `ans`=7.
